udp_tx_sched: RTL
=================

# udp_tx_sched

Two-channel scheduler in front of the UDP packetizer. Two producers (SSD read streams) each present a packet request with a word length and a pseudo-header checksum seed. The block arbitrates between them round-robin and drives the packetizer's `udp_start`, `length` and `sum_init`. It then tracks `udp_busy` through to completion and enforces an inter-packet gap and a watchdog timeout. It replaces direct NIOS control of the packetizer start and length inputs.

## Interface
Parameters:
- `START_W`, default 4: width of the `udp_start` pulse in cycles. Must be ≥3 because the packetizer synchronises `udp_start` through flops and edge-detects it.
- `MAX_LEN`, default 1003: largest legal packet length in 16-bit words (1024-word half buffer minus 21 header words).
- `TIMEOUT`, default 65535: watchdog limit in cycles for one packet.

Ports:
- `clk`  in  1  system clock.
- `nRST`  in  1  reset. One clock; reset is synchronous and active-low.
- `req0`, `req1`  in  1  channel request level. Held high until that channel's `ack`/`rej` pulse.
- `len0`, `len1`  in  16  channel packet length in words. Stable while the channel's `req` is high.
- `sum0`, `sum1`  in  32  channel checksum seed. Stable while the channel's `req` is high.
- `gap_cycles`  in  16  minimum idle cycles between packets (0 behaves as 1).
- `udp_busy`  in  1  packetizer busy.
- `udp_start`  out  1  start pulse to the packetizer.
- `length`  out  16  registered length to the packetizer.
- `sum_init`  out  32  registered seed to the packetizer.
- `ack0`, `ack1`  out  1  one-cycle pulse: packet sent.
- `rej0`, `rej1`  out  1  one-cycle pulse: request rejected (bad length or timeout).
- `pkt_cnt0`, `pkt_cnt1`  out  16  sent-packet counters. Wrap at 0xFFFF → 0.
- `timeout_err`  out  1  sticky watchdog flag. Cleared only by reset.
- `sched_busy`  out  1  high in every state except IDLE.

## Operation
- Reset (`nRST`=0 at a clk edge) forces:
  - state IDLE, round-robin pointer `rr` = 0;
  - all outputs 0 (`length`, `sum_init`, counters, flags, pulses);
  - internal counters 0.
- Reset mid-packet aborts with no ack/rej. Downstream is responsible for the packetizer's own reset.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:**
  - Neither `req` high → stay.
  - One `req` high → select that channel.
  - Both high → select channel `rr`.
  - For the selected channel k, latch `length` ← `lenk` and `sum_init` ← `sumk`.
  - If `lenk`==0 or `lenk`>`MAX_LEN`: pulse `rejk`, set `rr` ← ~k, go to GAP.
  - Otherwise go to START.
- **START:** `udp_start`=1 for exactly `START_W` cycles, then go to WAIT_BUSY (`udp_start`=0).
- **WAIT_BUSY:** wait for `udp_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE:** on `udp_busy`=0:
  - pulse `ackk`;
  - `pkt_cntk` += 1 (mod 2^16);
  - `rr` ← ~k;
  - go to GAP.
- **Watchdog:**
  - The counter clears on entry to START and counts every cycle in START, WAIT_BUSY and WAIT_DONE.
  - On reaching `TIMEOUT`: set `timeout_err`, pulse `rejk`, set `rr` ← ~k, go to GAP. The counter is not incremented.
  - If `udp_busy` falls in the same cycle the counter hits `TIMEOUT`, the completion wins (ack, not rej).
- **GAP:** count max(`gap_cycles`,1) cycles, then go to IDLE. Requests are not sampled in GAP, so requesters have ≥1 cycle after ack/rej to drop or update `req`.
- `length` and `sum_init` hold their value from selection until the next selection.

## Timing
- Selection to `udp_start` rise: 1 cycle. The IDLE-cycle decision is registered, and `udp_start` is high in the first START cycle.
- `ack`/`rej` are registered and are high in the first GAP cycle.
- `rej` for a bad length: high the cycle after the IDLE decision. No `udp_start` is issued.
- Back-to-back: a `req` held high is reselected in the first IDLE cycle after GAP.
- Minimum `ack` to next `udp_start` spacing = `gap_cycles` + 2.
- `udp_busy` is assumed already synchronous to `clk`.
- `udp_busy` already high on entry to WAIT_BUSY: advance to WAIT_DONE on the next edge.

## Test plan
- **Single request:** `req0`=1, `len0`=256, `sum0`=0x0001_2345.
  - `udp_start` high 4 cycles; `length`=256, `sum_init`=0x00012345.
  - Model drives busy for 300 cycles → `ack0` one pulse, `pkt_cnt0`=1.
- **Simultaneous requests:** `req0`=`req1`=1 held for 4 packets → served order 0,1,0,1; `pkt_cnt0`=`pkt_cnt1`=2.
- **Bad length:**
  - `len1`=0 → `rej1` pulse, no `udp_start`.
  - `len1`=1004 → `rej1`.
  - `len1`=1003 → accepted.
- **Timeout:** `TIMEOUT`=100, model never raises `udp_busy` → `rej0` exactly 100 cycles after START entry; `timeout_err`=1 and remains 1 across the next good packet.
- **Gap and wrap:**
  - `gap_cycles`=10 → measured `ack`-to-`udp_start` spacing is 12 cycles.
  - `pkt_cnt0` preset near wrap via 65536 packets (or force) → counter goes 0xFFFF→0.
- **Reset:** `nRST` low during WAIT_DONE → next cycle all outputs 0, state IDLE, no ack; held `req0` then restarts cleanly after release.

Source files
------------

// File: rtl/udp_tx_sched.sv
// Round-robin two-channel scheduler driving the UDP packetizer start,
// length and checksum seed, with busy tracking, inter-packet gap and watchdog.
module udp_tx_sched #(
  parameter int START_W = 4,
  parameter int MAX_LEN = 1003,
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] len0,
  input  logic [15:0] len1,
  input  logic [31:0] sum0,
  input  logic [31:0] sum1,
  input  logic [15:0] gap_cycles,
  input  logic        udp_busy,
  output logic        udp_start,
  output logic [15:0] length,
  output logic [31:0] sum_init,
  output logic        ack0,
  output logic        ack1,
  output logic        rej0,
  output logic        rej1,
  output logic [15:0] pkt_cnt0,
  output logic [15:0] pkt_cnt1,
  output logic        timeout_err,
  output logic        sched_busy
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WBUSY = 3'd2;
  localparam logic [2:0] S_WDONE = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [15:0] LEN_MAX = 16'(MAX_LEN);
  localparam logic [15:0] ST_LAST = 16'(START_W - 1);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  logic [2:0]  state;
  logic        rr;
  logic        sel;
  logic [15:0] st_cnt;
  logic [15:0] gap_cnt;
  logic [31:0] wd_cnt;

  logic        any_req;
  logic        pick;
  logic        bad_len;
  logic        wd_hit;
  logic [15:0] pick_len;
  logic [15:0] gap_len;
  logic [31:0] pick_sum;

  always_comb begin
    any_req  = req0 | req1;
    pick     = (req0 & req1) ? rr : req1;
    pick_len = pick ? len1 : len0;
    pick_sum = pick ? sum1 : sum0;
    bad_len  = (pick_len == 16'd0) || (pick_len > LEN_MAX);
    gap_len  = (gap_cycles == 16'd0) ? 16'd1 : gap_cycles;
    // watchdog fires on the cycle whose increment would reach TIMEOUT
    wd_hit   = (wd_cnt == WD_LAST);
  end

  assign sched_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state       <= S_IDLE;
      rr          <= 1'b0;
      sel         <= 1'b0;
      st_cnt      <= '0;
      gap_cnt     <= '0;
      wd_cnt      <= '0;
      udp_start   <= 1'b0;
      length      <= '0;
      sum_init    <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      rej0        <= 1'b0;
      rej1        <= 1'b0;
      pkt_cnt0    <= '0;
      pkt_cnt1    <= '0;
      timeout_err <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rej0 <= 1'b0;
      rej1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            sel      <= pick;
            length   <= pick_len;
            sum_init <= pick_sum;
            if (bad_len) begin
              if (pick) rej1 <= 1'b1;
              else      rej0 <= 1'b1;
              rr      <= ~pick;
              gap_cnt <= '0;
              state   <= S_GAP;
            end else begin
              udp_start <= 1'b1;
              st_cnt    <= '0;
              wd_cnt    <= '0;
              state     <= S_START;
            end
          end
        end
        S_START, S_WBUSY, S_WDONE: begin
          if (state == S_WDONE && !udp_busy) begin
            if (sel) begin
              ack1     <= 1'b1;
              pkt_cnt1 <= pkt_cnt1 + 16'd1;
            end else begin
              ack0     <= 1'b1;
              pkt_cnt0 <= pkt_cnt0 + 16'd1;
            end
            rr      <= ~sel;
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (wd_hit) begin
            if (sel) rej1 <= 1'b1;
            else     rej0 <= 1'b1;
            timeout_err <= 1'b1;
            udp_start   <= 1'b0;
            rr          <= ~sel;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
            if (state == S_START) begin
              if (st_cnt == ST_LAST) begin
                udp_start <= 1'b0;
                state     <= S_WBUSY;
              end else begin
                st_cnt <= st_cnt + 16'd1;
              end
            end else if (state == S_WBUSY && udp_busy) begin
              state <= S_WDONE;
            end
          end
        end
        S_GAP: begin
          // one extra cycle beyond the gap count gives ack-to-start of gap+2
          if (gap_cnt == gap_len) state <= S_IDLE;
          else gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
